// File: rtl/fifo_defs_pkg.sv
// Shared pointer helpers for the dual-clock FIFO (read and write controllers).
// Gray/binary conversion runs at a fixed maximum width; callers cast to their pointer width.
package fifo_defs;

  localparam int unsigned PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_max_t;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = '0;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module fifo_ptr_sync #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/re_control_lvl.sv
// Read-side FIFO controller: read pointers, registered empty, fill level,
// programmable almost-empty and sticky underflow, all in the read clock domain.
module re_control_lvl
  import fifo_defs::*;
#(
  parameter int unsigned ADDRWIDTH   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 rclk,
  input  logic                 rrstn,
  input  logic                 rpop,
  input  logic [ADDRWIDTH:0]   wptr,
  input  logic [ADDRWIDTH:0]   ae_thresh,
  input  logic                 clr_err,
  output logic [ADDRWIDTH-1:0] raddr,
  output logic [ADDRWIDTH:0]   rptr,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDRWIDTH:0]   rlevel,
  output logic                 runderflow
);

  localparam int unsigned PW = ptr_width(ADDRWIDTH);

  logic [PW-1:0] r_bin;
  logic [PW-1:0] w_wsync;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_bin_n;
  logic [PW-1:0] w_gray_n;
  logic [PW-1:0] w_level_n;
  logic          w_pop_ok;
  logic          w_underflow;

  fifo_ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .i_clk  (rclk),
    .i_rstn (rrstn),
    .i_d    (wptr),
    .o_q    (w_wsync)
  );

  assign w_pop_ok    = rpop & ~rempty;
  assign w_underflow = rpop & rempty;

  assign w_bin_n   = r_bin + {{(PW-1){1'b0}}, w_pop_ok};
  assign w_gray_n  = PW'(bin2gray(ptr_max_t'(w_bin_n)));
  assign w_wbin    = PW'(gray2bin(ptr_max_t'(w_wsync)));
  // Modulo subtraction keeps the level correct across pointer wrap.
  assign w_level_n = w_wbin - w_bin_n;

  always_ff @(posedge rclk) begin
    if (!rrstn) begin
      r_bin         <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
    end else begin
      r_bin         <= w_bin_n;
      rptr          <= w_gray_n;
      rempty        <= (w_gray_n == w_wsync);
      ralmost_empty <= (w_level_n <= ae_thresh);
      rlevel        <= w_level_n;
      // A new underflow wins over a simultaneous clear.
      runderflow    <= w_underflow | (runderflow & ~clr_err);
    end
  end

  assign raddr = r_bin[ADDRWIDTH-1:0];

endmodule

// File: tb/tb_re_control_lvl.sv
// Directed bench for re_control_lvl: stimulus queues hand-computed expectations,
// a monitor pops and compares them one cycle at a time.
module tb_re_control_lvl;

  localparam int AW = 4;
  localparam int PW = AW + 1;

  logic          rclk = 1'b0;
  logic          rrstn;
  logic          rpop;
  logic [PW-1:0] wptr;
  logic [PW-1:0] ae_thresh;
  logic          clr_err;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [PW-1:0] rlevel;
  logic          runderflow;

  always #5 rclk = ~rclk;

  re_control_lvl #(
    .ADDRWIDTH   (AW),
    .SYNC_STAGES (2)
  ) dut (
    .rclk          (rclk),
    .rrstn         (rrstn),
    .rpop          (rpop),
    .wptr          (wptr),
    .ae_thresh     (ae_thresh),
    .clr_err       (clr_err),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  typedef struct {
    int empty;
    int ae;
    int lvl;
    int addr;
    int uf;
    int ptr;
  } exp_t;

  exp_t          q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [PW-1:0] thr_next = 5'd2;

  function automatic logic [PW-1:0] g(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    if (exp >= 0) begin
      n_vec++;
      if (act != exp) begin
        n_err++;
        $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
    end
  endtask

  // Monitor: one expectation per clock edge, checked just after the edge.
  always @(posedge rclk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rempty",        int'(rempty),        e.empty);
      chk("ralmost_empty", int'(ralmost_empty), e.ae);
      chk("rlevel",        int'(rlevel),        e.lvl);
      chk("raddr",         int'(raddr),         e.addr);
      chk("runderflow",    int'(runderflow),    e.uf);
      chk("rptr",          int'(rptr),          e.ptr);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge (-1 = don't care).
  task automatic cyc(input logic rst_n, input logic pop, input logic clr, input logic [PW-1:0] wp,
                     input int e_empty, input int e_ae, input int e_lvl,
                     input int e_addr, input int e_uf, input int e_ptr);
    exp_t e;
    @(negedge rclk);
    rrstn     = rst_n;
    rpop      = pop;
    clr_err   = clr;
    wptr      = wp;
    ae_thresh = thr_next;
    e = '{e_empty, e_ae, e_lvl, e_addr, e_uf, e_ptr};
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rrstn = 1'b0; rpop = 1'b0; clr_err = 1'b0; wptr = '0; ae_thresh = 5'd2;

    // Reset with a pending pop and a non-zero write pointer
    repeat (2) cyc(0, 1, 0, 5'b00010, 1, 1, 0, 0, 0, 0);

    // Fill to 3: visible after three edges
    cyc(1, 0, 0, g(3), 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, g(3), 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, g(3), 0, 0, 3, 0, 0, 0);

    // Drain
    cyc(1, 1, 0, g(3), 0, 1, 2, 1, 0, int'(g(1)));
    cyc(1, 1, 0, g(3), 0, 1, 1, 2, 0, int'(g(2)));
    cyc(1, 1, 0, g(3), 1, 1, 0, 3, 0, 5'b00010);

    // Underflow, hold, clear, clear-vs-set, clear again
    cyc(1, 1, 0, g(3), 1, 1, 0, 3, 1, 5'b00010);
    cyc(1, 0, 0, g(3), 1, 1, 0, 3, 1, -1);
    cyc(1, 0, 1, g(3), 1, 1, 0, 3, 0, -1);
    cyc(1, 1, 1, g(3), 1, 1, 0, 3, 1, 5'b00010);
    cyc(1, 0, 0, g(3), 1, 1, 0, 3, 1, -1);
    cyc(1, 0, 1, g(3), 1, 1, 0, 3, 0, -1);

    // Full FIFO from rbin=0
    cyc(0, 0, 0, g(3), 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 5'b11000, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 5'b11000, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 5'b11000, 0, 0, 16, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      cyc(1, 1, 0, 5'b11000, int'(k == 16), int'((16 - k) <= 2), 16 - k, k % 16, 0, int'(g(k)));

    // Sixteen writes wrapping wptr to 0, level lags by two syncs
    for (int j = 1; j <= 16; j++)
      cyc(1, 0, 0, g(16 + j), int'(j <= 2), int'(j <= 4), (j > 2) ? j - 2 : 0, 0, 0, 5'b11000);
    cyc(1, 0, 0, 5'b00000, 0, 0, 15, 0, 0, 5'b11000);
    cyc(1, 0, 0, 5'b00000, 0, 0, 16, 0, 0, 5'b11000);

    // Sixteen pops: rbin wraps 31 -> 0
    for (int k = 1; k <= 16; k++)
      cyc(1, 1, 0, 5'b00000, int'(k == 16), int'((16 - k) <= 2), 16 - k, k % 16, 0, int'(g(16 + k)));

    // Level 5, then reset with a pop
    cyc(1, 0, 0, g(5), 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, g(5), 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, g(5), 0, 0, 5, 0, 0, 0);
    cyc(0, 1, 0, g(5), 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, g(5), 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, g(5), 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, g(5), 0, 0, 5, 0, 0, 0);

    // Threshold boundaries
    thr_next = 5'd16;
    cyc(1, 0, 0, g(5), 0, 1, 5, 0, 0, 0);
    thr_next = 5'd5;
    cyc(1, 0, 0, g(5), 0, 1, 5, 0, 0, 0);
    thr_next = 5'd4;
    cyc(1, 0, 0, g(5), 0, 0, 5, 0, 0, 0);
    thr_next = 5'd0;
    cyc(1, 0, 0, g(5), 0, 0, 5, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      cyc(1, 1, 0, g(5), int'(k == 5), int'(k == 5), 5 - k, k, 0, int'(g(k)));

    cyc(1, 0, 0, g(5), 1, 1, 0, 5, 0, int'(g(5)));
    @(negedge rclk);
    @(negedge rclk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
